jk_seq_driver: RTL and testbench

- Excitation-side driver for a bank of WIDTH JK flip-flops. It stores a programmable sequence of target states and, for each step, computes J/K from the live flop outputs (q_fb) and the target. It drives the J/K inputs, then checks that the bank reached the target.
- Sits in front of external jk_ff instances that share clk/reset; j_out/k_out connect to their J/K inputs, and their Q outputs feed back on q_fb.

---
 rtl/jk_seq_driver.sv | 203 ++++++++++++++++++++
 tb/tb_jk_seq_driver.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: excitation-side sequencer for a bank of external JK flops.
// A small sequence memory holds target states. For each step the block
// computes J/K from the live flop outputs and the target, drives them for
// one cycle, then holds the bank (J=K=0) and checks that it reached the
// target. The first mismatching step is latched in err_step.
module jk_seq_driver #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int USE_TOGGLE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  input  logic                       loop,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           q_fb,
  output logic [WIDTH-1:0]           j_out,
  output logic [WIDTH-1:0]           k_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH)-1:0]   err_step
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [WIDTH-1:0] TOG_L   = (USE_TOGGLE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // JK excitation table; don't-care positions take the toggle policy value.
  // Returns {J, K}.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] j_v;
    logic [WIDTH-1:0] k_v;
    j_v = (~q & t) | (q & TOG_L);
    k_v = (q & ~t) | (~q & TOG_L);
    return {j_v, k_v};
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic              loop_q, loop_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [AW-1:0]     err_step_q, err_step_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [LW-1:0]     len_eff_s;
  logic [AW-1:0]     ptr_inc_s;
  logic              last_s;
  logic              mismatch_s;
  logic [2*WIDTH-1:0] exc_first_s;
  logic [2*WIDTH-1:0] exc_next_s;

  // Sequence memory: cleared by reset, writable only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_L)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Derived step signals: clamped length, last-step flag, target compare,
  // and excitation for entry 0 and for the following entry.
  always_comb begin
    len_eff_s   = (len > DEPTH_L) ? DEPTH_L : len;
    ptr_inc_s   = ptr_q + AW'(1);
    last_s      = ({1'b0, ptr_q} == (len_q - LW'(1)));
    mismatch_s  = (q_fb != mem_q[ptr_q]);
    exc_first_s = excite(q_fb, mem_q[0]);
    if (last_s) begin
      exc_next_s = exc_first_s;
    end else begin
      exc_next_s = excite(q_fb, mem_q[ptr_inc_s]);
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    loop_d     = loop_q;
    j_d        = {WIDTH{1'b0}};
    k_d        = {WIDTH{1'b0}};
    done_d     = 1'b0;
    err_d      = err_q;
    err_step_d = err_step_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (len != {LW{1'b0}})) begin
          len_d      = len_eff_s;
          loop_d     = loop;
          err_d      = 1'b0;
          err_step_d = {AW{1'b0}};
          ptr_d      = {AW{1'b0}};
          j_d        = exc_first_s[2*WIDTH-1:WIDTH];
          k_d        = exc_first_s[WIDTH-1:0];
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        // The bank samples J/K on this edge; afterwards it is held.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (mismatch_s && !err_q) begin
            err_d      = 1'b1;
            err_step_d = ptr_q;
          end else begin
            err_d = err_q;
          end

          if (last_s && loop_q) begin
            ptr_d   = {AW{1'b0}};
            j_d     = exc_next_s[2*WIDTH-1:WIDTH];
            k_d     = exc_next_s[WIDTH-1:0];
            state_d = ST_DRIVE;
          end else if (last_s) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ptr_inc_s;
            j_d     = exc_next_s[2*WIDTH-1:WIDTH];
            k_d     = exc_next_s[WIDTH-1:0];
            state_d = ST_DRIVE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= {AW{1'b0}};
      len_q      <= {LW{1'b0}};
      loop_q     <= 1'b0;
      j_q        <= {WIDTH{1'b0}};
      k_q        <= {WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= {AW{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      j_q        <= j_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
    end
  end

  assign j_out    = j_q;
  assign k_out    = k_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_step = err_step_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: two instances (USE_TOGGLE 0 and 1), each closing
// the loop through a behavioural 4-bit JK flop bank.
module tb_jk_seq_driver;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] len;
  logic       start;
  logic       loop;
  logic       abort;

  logic [3:0] j0, k0, j1, k1;
  logic       busy0, done0, err0, busy1, done1, err1;
  logic [2:0] err_step0, err_step1;
  logic [3:0] q0_r, q1_r, q_fb0, q_fb1;
  logic [3:0] stuck_mask;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
  } vec_t;

  vec_t tv[5];

  jk_seq_driver #(.WIDTH(4), .DEPTH(8), .USE_TOGGLE(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .start(start), .loop(loop),
    .abort(abort), .q_fb(q_fb0), .j_out(j0), .k_out(k0), .busy(busy0),
    .done(done0), .err(err0), .err_step(err_step0)
  );

  jk_seq_driver #(.WIDTH(4), .DEPTH(8), .USE_TOGGLE(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len(len), .start(start), .loop(loop),
    .abort(abort), .q_fb(q_fb1), .j_out(j1), .k_out(k1), .busy(busy1),
    .done(done1), .err(err1), .err_step(err_step1)
  );

  // JK flop banks sharing clk/reset with the drivers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0_r <= 4'h0;
      q1_r <= 4'h0;
    end else begin
      q0_r <= (j0 & ~q0_r) | (~k0 & q0_r);
      q1_r <= (j1 & ~q1_r) | (~k1 & q1_r);
    end
  end

  assign q_fb0 = q0_r & ~stuck_mask;
  assign q_fb1 = q1_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] l, input logic lp);
    len   = l;
    loop  = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One step from its DRIVE cycle: check J/K, then the bank in CHECK.
  task automatic do_step(input int d, input string tag,
                         input logic [3:0] ej, input logic [3:0] ek,
                         input logic [3:0] eq);
    chk({tag, " j"}, (d == 1) ? j1 : j0, ej);
    chk({tag, " k"}, (d == 1) ? k1 : k0, ek);
    tick();
    chk({tag, " q"}, (d == 1) ? q_fb1 : q_fb0, eq);
    chk({tag, " done_low"}, (d == 1) ? done1 : done0, 1'b0);
    tick();
  endtask

  // Cycle right after the last CHECK: one done pulse, back to idle.
  task automatic end_run(input int d, input string tag);
    chk({tag, " done"}, (d == 1) ? done1 : done0, 1'b1);
    chk({tag, " busy_end"}, (d == 1) ? busy1 : busy0, 1'b0);
    tick();
    chk({tag, " done_pulse"}, (d == 1) ? done1 : done0, 1'b0);
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 4'h0;
    len        = 4'd0;
    start      = 1'b0;
    loop       = 1'b0;
    abort      = 1'b0;
    stuck_mask = 4'h0;

    tv[0] = '{4'h1, 4'h1, 4'h0};
    tv[1] = '{4'h3, 4'h2, 4'h0};
    tv[2] = '{4'h7, 4'h4, 4'h0};
    tv[3] = '{4'hF, 4'h8, 4'h0};
    tv[4] = '{4'h0, 4'h0, 4'hF};

    tick();
    tick();
    chk("rst j", j0, 4'h0);
    chk("rst k", k0, 4'h0);
    chk("rst busy", busy0, 1'b0);
    chk("rst done", done0, 1'b0);
    chk("rst err", err0, 1'b0);
    chk("rst err_step", err_step0, 3'd0);
    reset = 1'b1;
    tick();

    // 1: incrementing fill then clear, USE_TOGGLE=0.
    for (int i = 0; i < 5; i++) write_mem(3'(i), tv[i].tgt);
    start_run(4'd5, 1'b0);
    chk("t1 busy", busy0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_step(0, $sformatf("t1 s%0d", i), tv[i].exp_j, tv[i].exp_k, tv[i].tgt);
    end
    end_run(0, "t1");
    chk("t1 err", err0, 1'b0);

    // 2: toggle policy instance, 0 then F from a zero bank.
    write_mem(3'd0, 4'h0);
    write_mem(3'd1, 4'hF);
    start_run(4'd2, 1'b0);
    do_step(1, "t2 s0", 4'h0, 4'hF, 4'h0);
    do_step(1, "t2 s1", 4'hF, 4'hF, 4'hF);
    end_run(1, "t2");
    chk("t2 err", err1, 1'b0);

    // 3: bit0 of bank 0 stuck low; raw bank is F, feedback reads E.
    stuck_mask = 4'h1;
    write_mem(3'd0, 4'h1);
    write_mem(3'd1, 4'h2);
    write_mem(3'd2, 4'h3);
    start_run(4'd3, 1'b0);
    do_step(0, "t3 s0", 4'h1, 4'hE, 4'h0);
    chk("t3 err_set", err0, 1'b1);
    chk("t3 err_step0", err_step0, 3'd0);
    do_step(0, "t3 s1", 4'h2, 4'h0, 4'h2);
    do_step(0, "t3 s2", 4'h1, 4'h0, 4'h2);
    end_run(0, "t3");
    chk("t3 err_end", err0, 1'b1);
    chk("t3 err_step_end", err_step0, 3'd0);
    stuck_mask = 4'h0;

    // 4: looping A,5 for three periods, then abort in CHECK. Bank starts at 3.
    write_mem(3'd0, 4'hA);
    write_mem(3'd1, 4'h5);
    start_run(4'd2, 1'b1);
    chk("t4 err_cleared", err0, 1'b0);
    do_step(0, "t4 s0", 4'h8, 4'h1, 4'hA);
    for (int p = 0; p < 2; p++) begin
      do_step(0, "t4 a5", 4'h5, 4'hA, 4'h5);
      do_step(0, "t4 5a", 4'hA, 4'h5, 4'hA);
    end
    chk("t4 last j", j0, 4'h5);
    chk("t4 last k", k0, 4'hA);
    tick();
    chk("t4 last q", q_fb0, 4'h5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4 abort busy", busy0, 1'b0);
    chk("t4 abort j", j0, 4'h0);
    chk("t4 abort k", k0, 4'h0);
    chk("t4 abort done", done0, 1'b0);
    tick();
    chk("t4 abort done2", done0, 1'b0);

    // 5: async reset during step 2. Bank starts at 5.
    write_mem(3'd0, 4'h1);
    write_mem(3'd1, 4'h3);
    write_mem(3'd2, 4'h7);
    start_run(4'd3, 1'b0);
    do_step(0, "t5 s0", 4'h0, 4'h4, 4'h1);
    do_step(0, "t5 s1", 4'h2, 4'h0, 4'h3);
    chk("t5 s2 j", j0, 4'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("t5 rst j", j0, 4'h0);
    chk("t5 rst k", k0, 4'h0);
    chk("t5 rst busy", busy0, 1'b0);
    chk("t5 rst err", err0, 1'b0);
    chk("t5 rst q", q_fb0, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    start_run(4'd1, 1'b0);
    do_step(0, "t5 cleared", 4'h0, 4'h0, 4'h0);
    end_run(0, "t5 cleared");
    write_mem(3'd0, 4'h1);
    write_mem(3'd1, 4'h3);
    start_run(4'd2, 1'b0);
    do_step(0, "t5 r0", 4'h1, 4'h0, 4'h1);
    do_step(0, "t5 r1", 4'h2, 4'h0, 4'h3);
    end_run(0, "t5 rerun");
    chk("t5 err", err0, 1'b0);

    // 6a: write while busy is dropped. Bank at 3, mem = 1,3.
    start_run(4'd2, 1'b0);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 4'hF;
    do_step(0, "t6 s0", 4'h0, 4'h2, 4'h1);
    wr_en = 1'b0;
    do_step(0, "t6 s1", 4'h2, 4'h0, 4'h3);
    end_run(0, "t6 busywr");
    start_run(4'd1, 1'b0);
    do_step(0, "t6 readback", 4'h0, 4'h2, 4'h1);
    end_run(0, "t6 readback");

    // 6b: len=0 start is ignored.
    start_run(4'd0, 1'b0);
    chk("t6 len0 busy", busy0, 1'b0);
    tick();
    chk("t6 len0 busy2", busy0, 1'b0);

    // 6c: len=12 clamps to 8 steps (16 edges to done).
    for (int i = 0; i < 8; i++) write_mem(3'(i), 4'(i + 2));
    len   = 4'd12;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t6 len12 edges", n, 16);
    chk("t6 len12 q", q_fb0, 4'h9);
    chk("t6 len12 err", err0, 1'b0);
    chk("t6 len12 busy", busy0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
